// File: rtl/nibble_logic_seq_pkg.sv
// -----------------------------------------------------------------------------
// nls_pkg
// Shared constants for the nibble logic sequencer:
//   NIB_W      width of one pass through the quad-gate chip
//   OP_*       operation / chip-select encodings (11 is reserved, handled as AND)
//   ST_*       sequencer state encodings
//   widthOf()  counter width helper that never returns less than one bit
// -----------------------------------------------------------------------------
package nls_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Bits needed to hold the values 0..n-1, with a floor of one bit so that
  // degenerate configurations still get a legal vector.
  function automatic int widthOf(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_logic_seq_if.sv
// -----------------------------------------------------------------------------
// nibble_logic_seq_if
// Bundles the ALU-control side and the chip-pin side of the sequencer.
//   start/op/opa/opb   request from ALU control
//   busy/done/result   status and result back to ALU control
//   gate_a/gate_b      operand pins a4..a1 / b4..b1 of the shared chip
//   gate_sel           chip select (latched op)
//   gate_y             output pins y4..y1 of the chip
// master: ALU control plus chip model; slave: the sequencer.
// -----------------------------------------------------------------------------
interface nibble_logic_seq_if #(
  parameter int NIBBLES = 2
);

  logic                              start;
  logic [1:0]                        op;
  logic [nls_pkg::NIB_W*NIBBLES-1:0] opa;
  logic [nls_pkg::NIB_W*NIBBLES-1:0] opb;
  logic                              busy;
  logic                              done;
  logic [nls_pkg::NIB_W*NIBBLES-1:0] result;
  logic [nls_pkg::NIB_W-1:0]         gate_a;
  logic [nls_pkg::NIB_W-1:0]         gate_b;
  logic [1:0]                        gate_sel;
  logic [nls_pkg::NIB_W-1:0]         gate_y;

  modport master (
    output start, op, opa, opb, gate_y,
    input  busy, done, result, gate_a, gate_b, gate_sel
  );

  modport slave (
    input  start, op, opa, opb, gate_y,
    output busy, done, result, gate_a, gate_b, gate_sel
  );

endinterface

// File: rtl/nibble_logic_seq_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that measures how long the chip operands have been
// held. Counts down to zero and parks there until reloaded.
//   clk, rst_n   clock and synchronous active-low reset
//   i_load       load i_loadVal (takes priority over counting)
//   i_loadVal    reload value
//   i_dec        count down by one while non-zero
//   o_zero       counter has reached zero (last cycle of the window)
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/nibble_logic_seq.sv
// -----------------------------------------------------------------------------
// nibble_logic_seq
// Runs a 4*NIBBLES-bit bitwise operation through one external quad-gate
// chip, one nibble per pass: drive a/b pins, hold them SETTLE_CYCLES+1
// cycles, capture the y pins into the matching result nibble.
//   clk, rst_n   clock and synchronous active-low reset
//   bus          slave side of nibble_logic_seq_if (request, status, chip pins)
// -----------------------------------------------------------------------------
module nibble_logic_seq
  import nls_pkg::*;
#(
  parameter int NIBBLES       = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_logic_seq_if.slave   bus
);

  localparam int DW = NIB_W * NIBBLES;
  localparam int TW = widthOf(SETTLE_CYCLES + 1);
  localparam int IW = widthOf(NIBBLES);

  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NIBBLES - 1);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_index;
  logic [DW-1:0]    r_opa;
  logic [DW-1:0]    r_opb;
  logic [1:0]       r_op;
  logic [DW-1:0]    r_result;

  logic             w_drive;
  logic             w_accept;
  logic             w_zero;
  logic             w_reload;
  logic [NIB_W-1:0] w_nibA;
  logic [NIB_W-1:0] w_nibB;

  // A request is taken whenever the block is not busy, which includes the
  // FINISH cycle so that back-to-back operations need no idle gap.
  assign w_drive  = (r_state == ST_DRIVE);
  assign w_accept = bus.start && !w_drive;
  assign w_reload = w_drive && w_zero && (r_index != LAST_IDX);

  settle_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept || w_reload),
    .i_loadVal (SETTLE_LOAD),
    .i_dec     (w_drive),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_index  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_DRIVE: begin
          // Capture on the last cycle of the settle window only.
          if (w_zero) begin
            r_result[r_index*NIB_W +: NIB_W] <= bus.gate_y;
            if (r_index == LAST_IDX) begin
              r_state <= ST_FINISH;
            end else begin
              r_index <= r_index + IW'(1);
            end
          end
        end
        default: begin
          // IDLE, FINISH and the unused encoding all behave as "not busy".
          if (bus.start) begin
            r_opa   <= bus.opa;
            r_opb   <= bus.opb;
            r_op    <= bus.op;
            r_index <= '0;
            r_state <= ST_DRIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign w_nibA = r_opa[r_index*NIB_W +: NIB_W];
  assign w_nibB = r_opb[r_index*NIB_W +: NIB_W];

  assign bus.gate_a   = w_drive ? w_nibA : '0;
  assign bus.gate_b   = w_drive ? w_nibB : '0;
  assign bus.gate_sel = r_op;
  assign bus.busy     = w_drive;
  assign bus.done     = (r_state == ST_FINISH);
  assign bus.result   = r_result;

endmodule

// File: tb/tb_nibble_logic_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_logic_seq
// Two sequencer instances (NIBBLES=2/SETTLE=1 and NIBBLES=1/SETTLE=0), each
// wired to a behavioural 74xx08/32/86 chip selected by gate_sel. Stimulus
// pushes expected result, op and done cycle into a queue; a monitor per
// instance pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_nibble_logic_seq;
  import nls_pkg::*;

  localparam int LAT_A = 2 * (1 + 1);
  localparam int LAT_B = 1 * (0 + 1);

  typedef struct {
    logic [7:0] res;
    logic [1:0] op;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstA_n;
  logic rstB_n;
  int   edgeCnt = 0;
  int   passCount = 0;
  int   totalCount = 0;
  exp_t qA[$];
  exp_t qB[$];

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  nibble_logic_seq_if #(.NIBBLES(2)) busA ();
  nibble_logic_seq_if #(.NIBBLES(1)) busB ();

  nibble_logic_seq #(.NIBBLES(2), .SETTLE_CYCLES(1)) dutA (
    .clk   (clk),
    .rst_n (rstA_n),
    .bus   (busA.slave)
  );

  nibble_logic_seq #(.NIBBLES(1), .SETTLE_CYCLES(0)) dutB (
    .clk   (clk),
    .rst_n (rstB_n),
    .bus   (busB.slave)
  );

  // One quad-gate package; the select picks which pin-compatible part it is.
  function automatic logic [3:0] chipModel(input logic [1:0] sel, input logic [3:0] a,
                                           input logic [3:0] b);
    case (sel)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign busA.gate_y = chipModel(busA.gate_sel, busA.gate_a, busA.gate_b);
  assign busB.gate_y = chipModel(busB.gate_sel, busB.gate_a, busB.gate_b);

  // Whole-word reference of the requested operation.
  function automatic logic [7:0] refModel(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    if (op == OP_OR)  return a | b;
    if (op == OP_XOR) return a ^ b;
    return a & b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raises start with the given request and records the expected response.
  task automatic applyStimulus(input bit toB, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b);
    exp_t e;
    e.res = refModel(op, a, b);
    e.op  = op;
    e.cyc = edgeCnt + 1 + (toB ? LAT_B : LAT_A);
    if (toB) begin
      busB.op = op; busB.opa = a[3:0]; busB.opb = b[3:0]; busB.start = 1'b1;
      e.res = e.res & 8'h0F;
      qB.push_back(e);
    end else begin
      busA.op = op; busA.opa = a; busA.opb = b; busA.start = 1'b1;
      qA.push_back(e);
    end
  endtask

  // One full operation; operands are scrambled while busy and the task
  // returns in the FINISH cycle so a following call runs back-to-back.
  task automatic runOp(input bit toB, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    applyStimulus(toB, op, a, b);
    tick;
    if (toB) begin
      busB.start = 1'b0; busB.opa = 4'($urandom); busB.opb = 4'($urandom);
      busB.op = 2'($urandom);
      repeat (LAT_B) tick;
    end else begin
      busA.start = 1'b0; busA.opa = 8'($urandom); busA.opb = 8'($urandom);
      busA.op = 2'($urandom);
      repeat (LAT_A) tick;
    end
  endtask

  always @(negedge clk) begin : monA
    exp_t e;
    if (rstA_n === 1'b1 && busA.done === 1'b1) begin
      checkOutput("A done expected", 32'(qA.size() > 0), 32'd1);
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput("A result", 32'(busA.result), 32'(e.res));
        checkOutput("A done cycle", 32'(edgeCnt), 32'(e.cyc));
        checkOutput("A gate_sel at done", 32'(busA.gate_sel), 32'(e.op));
        checkOutput("A busy at done", 32'(busA.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (rstB_n === 1'b1 && busB.done === 1'b1) begin
      checkOutput("B done expected", 32'(qB.size() > 0), 32'd1);
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput("B result", 32'(busB.result), 32'(e.res));
        checkOutput("B done cycle", 32'(edgeCnt), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstA_n = 1'b0; rstB_n = 1'b0;
    busA.start = 1'b0; busA.op = '0; busA.opa = '0; busA.opb = '0;
    busB.start = 1'b0; busB.op = '0; busB.opa = '0; busB.opb = '0;
    repeat (3) tick;
    @(negedge clk);
    checkOutput("A reset busy", 32'(busA.busy), 32'd0);
    checkOutput("A reset done", 32'(busA.done), 32'd0);
    checkOutput("A reset result", 32'(busA.result), 32'd0);
    checkOutput("A reset gate_a", 32'(busA.gate_a), 32'd0);
    checkOutput("A reset gate_b", 32'(busA.gate_b), 32'd0);
    checkOutput("A reset gate_sel", 32'(busA.gate_sel), 32'd0);
    checkOutput("B reset result", 32'(busB.result), 32'd0);
    tick;
    rstA_n = 1'b1; rstB_n = 1'b1;
    tick;

    fork
      begin
        // Directed AND with per-cycle pin checks.
        applyStimulus(1'b0, OP_AND, 8'hC5, 8'h3F);
        tick;
        busA.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
          @(negedge clk);
          checkOutput($sformatf("A gate_a cycle %0d", c), 32'(busA.gate_a), (c <= 2) ? 32'h5 : 32'hC);
          checkOutput($sformatf("A gate_b cycle %0d", c), 32'(busA.gate_b), (c <= 2) ? 32'hF : 32'h3);
          checkOutput($sformatf("A gate_sel cycle %0d", c), 32'(busA.gate_sel), 32'(OP_AND));
          checkOutput($sformatf("A busy cycle %0d", c), 32'(busA.busy), 32'd1);
          tick;
        end
        tick;
        @(negedge clk);
        checkOutput("A idle gate_a", 32'(busA.gate_a), 32'd0);
        checkOutput("A idle busy", 32'(busA.busy), 32'd0);
        tick;

        runOp(1'b0, OP_OR, 8'hA0, 8'h0A);
        runOp(1'b0, OP_XOR, 8'hFF, 8'h0F);
        tick;

        // Second start while busy must be ignored.
        applyStimulus(1'b0, OP_AND, 8'h9C, 8'h5A);
        tick;
        busA.start = 1'b0;
        tick;
        busA.start = 1'b1; busA.opa = 8'h00; busA.opb = 8'hFF;
        tick;
        busA.start = 1'b0;
        repeat (LAT_A - 2) tick;
        tick;

        // Reset in the middle of an operation.
        applyStimulus(1'b0, OP_OR, 8'h12, 8'h34);
        tick;
        busA.start = 1'b0;
        tick;
        tick;
        rstA_n = 1'b0;
        qA.delete();
        tick;
        @(negedge clk);
        checkOutput("A midreset busy", 32'(busA.busy), 32'd0);
        checkOutput("A midreset result", 32'(busA.result), 32'd0);
        checkOutput("A midreset gate_a", 32'(busA.gate_a), 32'd0);
        checkOutput("A midreset gate_b", 32'(busA.gate_b), 32'd0);
        tick;
        rstA_n = 1'b1;
        repeat (3) tick;
        runOp(1'b0, OP_XOR, 8'h5A, 8'h3C);
        tick;

        // Back-to-back: start held high straight through FINISH.
        applyStimulus(1'b0, OP_AND, 8'hF0, 8'hCC);
        tick;
        busA.opa = 8'h11; busA.opb = 8'h22; busA.op = OP_OR;
        repeat (LAT_A) tick;
        runOp(1'b0, OP_OR, 8'h11, 8'h22);
        tick;

        repeat (20) begin
          runOp(1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) tick;
        end
        repeat (3) tick;
      end
      begin
        applyStimulus(1'b1, OP_AND, 8'h06, 8'h03);
        tick;
        busB.start = 1'b0;
        @(negedge clk);
        checkOutput("B gate_a drive", 32'(busB.gate_a), 32'h6);
        checkOutput("B gate_b drive", 32'(busB.gate_b), 32'h3);
        repeat (LAT_B) tick;
        tick;
        repeat (15) begin
          runOp(1'b1, 2'($urandom), 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) tick;
        end
        repeat (3) tick;
      end
    join

    checkOutput("A all dones seen", 32'(qA.size()), 32'd0);
    checkOutput("B all dones seen", 32'(qB.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/nibble_logic_seq.md
Name: nibble_logic_seq

Overview:
- Sequencer that performs an N-nibble bitwise logic operation using one shared 4-gate 74xx logic chip (08 AND / 32 OR / 86 XOR pin variants), one nibble per pass.
- Drives the chip's a1..a4 / b1..b4 pins, waits a settle window, then samples y1..y4.
- Sits between the emulator's ALU control and the gate-level chip models, so wide operations reuse a single quad-gate package.

Parameters:
- NIBBLES, 2, number of 4-bit passes; operand width = 4*NIBBLES (≥1).
- SETTLE_CYCLES, 1, extra cycles operands are held before sampling (≥0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only when busy=0.
- op  in  2  00=AND, 01=OR, 10=XOR, 11=reserved (treated as AND).
- opa  in  4*NIBBLES  operand A, sampled on the accepting edge.
- opb  in  4*NIBBLES  operand B, sampled on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  4*NIBBLES  registered result, held until the next accepted start.
- gate_a  out  4  to chip a4..a1 (bit0 = a1).
- gate_b  out  4  to chip b4..b1.
- gate_sel  out  2  chip select (= latched op).
- gate_y  in  4  from chip y4..y1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy=0, done=0, result=0, gate_a=0, gate_b=0, gate_sel=0; nibble index=0, settle counter=0. Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, DRIVE, FINISH.
- IDLE: gate_a and gate_b are driven 0. On start=1, latch opa, opb and op, set index=0 and counter=SETTLE_CYCLES, then go to DRIVE with busy=1.
- DRIVE: gate_a = opa nibble[index] and gate_b = opb nibble[index], stable for the whole window of SETTLE_CYCLES+1 cycles. In the window's last cycle (counter=0), the edge writes gate_y into result nibble[index].
  - If index < NIBBLES-1: increment index, reload counter, stay in DRIVE.
  - Otherwise: go to FINISH.
- FINISH: lasts one cycle; done=1, busy=0, gate_a and gate_b = 0. Next state IDLE, or DRIVE if start=1 in this cycle (back-to-back start allowed).
- Latency: done is high NIBBLES*(SETTLE_CYCLES+1)+1 cycles after the accepting edge. Default: start accepted at edge 0, done visible in cycle 5 (after edge 4).
- start while busy=1 is ignored and not queued. opa, opb and op changes while busy have no effect.
- result nibbles are updated in place during an operation. Only the value while done=1 is guaranteed.
- gate_sel is held constant from the accepting edge until IDLE is re-entered.
- The block performs no logic itself: result is exactly the sampled gate_y, with no masking.

Decomposition:
- Shared package nls_pkg: op encodings OP_AND/OP_OR/OP_XOR, state localparams, nibble width constant 4.
- Sub-module settle_timer: loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1) (min 1).

Test Plan:
- AND, opa=8'hC5, opb=8'h3F, bench models a 74xx08 → gate_a/gate_b = 5/F in cycles 1–2, C/3 in cycles 3–4; done in cycle 5 with result=8'h05; gate_sel=00 throughout.
- OR, opa=8'hA0, opb=8'h0A with a 74xx32 model → result=8'hAA. XOR, opa=8'hFF, opb=8'h0F with a 74xx86 model → result=8'hF0.
- start re-pulsed in cycle 2 with opa=8'h00 → ignored; first result unchanged; exactly one done pulse.
- rst_n=0 at the cycle-3 edge → busy=0, result=0, gate_a/gate_b=0 in the next cycle; no done pulse; a new start completes normally.
- Back-to-back: start held high through FINISH → second operation accepted at that edge, no idle cycle; two done pulses 5 cycles apart.
- SETTLE_CYCLES=0, NIBBLES=1: opa=4'h6, opb=4'h3, AND → done two cycles after acceptance, result=4'h2.
